// File: rtl/pipeline_inverse_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_inverse_if
// Description : Request/response bundle between a requester and the
//               pipeline_inverse search engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_inverse_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] out;

    modport master (
        output start,
        output in,
        input  busy,
        input  done,
        input  found,
        input  out
    );

    modport slave (
        input  start,
        input  in,
        output busy,
        output done,
        output found,
        output out
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_inverse.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_inverse
// Description : Recovers the smallest X with (2*X^2 + 2) mod 2^WIDTH == Y by
//               an ascending search, one candidate per clock, multiplier-free.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_inverse #(
    parameter int WIDTH = 8
) (
    input  wire                 clk,
    input  wire                 rst_n,
    pipeline_inverse_if.slave   bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_search = 2'd1;
    localparam logic [1:0] c_st_report = 2'd2;

    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_f0   = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] c_xmax = {WIDTH{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_f;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_out;
    logic             r_found;

    logic             w_match;
    logic             w_last;
    logic [WIDTH-1:0] w_step;
    logic             w_busy;
    logic             w_done;

    assign w_match = (r_f == r_y);
    assign w_last  = (r_x == c_xmax);
    // f(X+1) - f(X) = 4X + 2, truncated to WIDTH bits
    assign w_step  = {r_x[WIDTH-3:0], 2'b10};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_state_nxt = c_st_search;
                end
            end
            c_st_search: begin
                if (w_match || w_last) begin
                    w_state_nxt = c_st_report;
                end
            end
            c_st_report: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_st_search: w_busy = 1'b1;
            c_st_report: w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Result registers hold their last value until the next search reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_f     <= '0;
            r_y     <= '0;
            r_out   <= '0;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_y <= bus.in;
                        r_x <= '0;
                        r_f <= c_f0;
                    end
                end
                c_st_search: begin
                    if (w_match) begin
                        r_out   <= r_x;
                        r_found <= 1'b1;
                    end else if (w_last) begin
                        r_out   <= '0;
                        r_found <= 1'b0;
                    end else begin
                        r_x <= r_x + c_one;
                        r_f <= r_f + w_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.found = r_found;
    assign bus.out   = r_out;

endmodule
`default_nettype wire

// File: doc/pipeline_inverse.md
Name: pipeline_inverse

Overview:
- Sequential decoder for the 8-bit arithmetic pipeline, which computes OUT = (2*IN^2 + 2) mod 2^WIDTH.
- Given a pipeline result Y, this block recovers the smallest input X with f(X) == Y.
- It uses an incremental exhaustive search, one candidate per clock, with no multiplier.
- It sits behind the pipeline output and checks or decodes pipeline results in self-check and loopback configurations.

Parameters:
- WIDTH, 8, data width of Y and X; the search space is 0 .. 2^WIDTH-1.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- IN  input  WIDTH  target value Y; latched on the accepting edge.
- BUSY  output  1  high while in SEARCH.
- DONE  output  1  one-cycle pulse when the result is valid.
- FOUND  output  1  1 if a matching X exists, 0 if no X maps to Y.
- OUT  output  WIDTH  recovered X (0 when FOUND=0).

Behaviour:
- Reset: RST_N=0 immediately (asynchronously) forces state=IDLE, BUSY=0, DONE=0, FOUND=0, OUT=0, and clears internal X, F and Y_lat.
- States: IDLE, SEARCH, REPORT.
- IDLE, START=1 at edge E0:
  - Y_lat <= IN, X <= 0, F <= 2 (that is, f(0)).
  - Go to SEARCH.
  - OUT and FOUND keep their previous values until REPORT.
- IDLE, START=0: stay in IDLE.
- SEARCH, each edge:
  - If F == Y_lat: OUT <= X, FOUND <= 1, go to REPORT.
  - Else if X == 2^WIDTH-1: OUT <= 0, FOUND <= 0, go to REPORT.
  - Else: X <= X+1, F <= F + 4*X + 2 (mod 2^WIDTH), using the current X; stay in SEARCH.
- REPORT: DONE=1 for exactly this one cycle, then unconditionally return to IDLE.
- Outputs:
  - BUSY = (state == SEARCH).
  - DONE = (state == REPORT).
  - Both are registered-state decodes, glitch-free.
- Latency:
  - Match at X=k: REPORT is entered at edge E0+k+1, so DONE is high during the cycle after that edge.
  - No match: REPORT is entered at edge E0+2^WIDTH (256 search cycles for WIDTH=8).
- Smallest X wins: the search is ascending and terminates on the first match.
- Arithmetic:
  - F is WIDTH bits, wraps modulo 2^WIDTH.
  - 4*X+2 is truncated to WIDTH bits before the add.
  - Invariant: F == (2*X^2+2) mod 2^WIDTH at every SEARCH cycle.
- START while BUSY or in REPORT: ignored; no queueing.
  - START held high continuously re-triggers from IDLE on the edge after REPORT.
- IN changes during SEARCH: no effect (Y_lat is used).
- Odd Y: f is always even, so the result is always FOUND=0 after the full search.
- X counter must not wrap; termination at 2^WIDTH-1 is mandatory.
- Reset asserted mid-SEARCH: abort immediately to IDLE with all outputs 0; no DONE pulse.

Test Plan:
- Reset, then START=1 with IN=10 for one cycle:
  - BUSY high for 3 cycles.
  - DONE pulses once at the 4th cycle after the accepting edge.
  - OUT=2, FOUND=1.
- Sequential requests, each awaiting DONE before the next:
  - IN=2 gives OUT=0.
  - IN=20 gives OUT=3.
  - IN=52 gives OUT=5.
  - IN=100 gives OUT=7.
  - IN=164 gives OUT=9.
  - FOUND=1 in all cases; the DONE edge equals E0+OUT+1.
- IN=3 (odd) and IN=0 (unreachable):
  - DONE after exactly 256 BUSY cycles.
  - FOUND=0, OUT=0.
- Mid-search disturbances:
  - Set IN=130; after START, change IN to 7 and pulse START again while BUSY.
  - Result is OUT=8, FOUND=1, with a single DONE pulse.
- Reset mid-search:
  - START with IN=3, then assert RST_N=0 for half a cycle at cycle 50.
  - Outputs go to 0 asynchronously; no DONE occurs.
  - A following request with IN=4 returns OUT=1.
- Loopback with the pipeline:
  - Feed IN=2..9 through the pipeline and present each pipeline OUT here.
  - Each recovered OUT equals the original input, with FOUND=1.
